// File: rtl/axi_wb_pkg.sv
// Shared definitions for the AXI4-lite to Wishbone bridge.
package axi_wb_pkg;

  localparam int AXI_DW     = 32;
  localparam int AXI_AW     = 32;
  localparam int TMO_CYCLES = 1024;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WB_WR,
    WB_RD,
    B_RESP,
    R_RESP
  } state_e;

endpackage

// File: rtl/axil2wb_skid.sv
// Single-entry holding register: accepts one beat, releases it on pop.
module axil2wb_skid #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  input  logic         pop_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q;
  logic [W-1:0] data_q;

  // Capture on handshake; release when the consumer launches the transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (valid_i && !full_q) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign ready_o = !full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axil2wb_bridge.sv
// AXI4-lite slave to Wishbone classic master, one transaction in flight,
// fair read/write arbitration and a bus-hang timeout.
module axil2wb_bridge
  import axi_wb_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = AXI_DW,
  parameter int C_AXI_ADDR_WIDTH = AXI_AW,
  parameter int TIMEOUT_CYCLES   = TMO_CYCLES
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          i_axi_awvalid,
  output logic                          o_axi_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_awaddr,
  input  logic                          i_axi_wvalid,
  output logic                          o_axi_wready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] i_axi_wstrb,
  output logic                          o_axi_bvalid,
  input  logic                          i_axi_bready,
  output logic [1:0]                    o_axi_bresp,
  input  logic                          i_axi_arvalid,
  output logic                          o_axi_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_araddr,
  output logic                          o_axi_rvalid,
  input  logic                          i_axi_rready,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_axi_rdata,
  output logic [1:0]                    o_axi_rresp,
  output logic                          o_wb_rst,
  output logic                          o_wb_cyc,
  output logic                          o_wb_stb,
  output logic                          o_wb_we,
  output logic [C_AXI_ADDR_WIDTH-3:0]   o_wb_adr,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_wb_dat,
  output logic [C_AXI_DATA_WIDTH/8-1:0] o_wb_sel,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_wb_dat,
  input  logic                          i_wb_ack,
  input  logic                          i_wb_err
);

  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = C_AXI_DATA_WIDTH / 8;
  localparam int WA = C_AXI_ADDR_WIDTH - 2;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic          aw_full, w_full, ar_full;
  logic [WA-1:0] aw_adr, ar_adr;
  logic [SW+DW-1:0] w_data;

  state_e        state_q;
  logic          lwr_q;
  logic          cyc_q, stb_q, we_q;
  logic [WA-1:0] adr_q;
  logic [DW-1:0] dat_q;
  logic [SW-1:0] sel_q;
  logic [TW-1:0] tmo_q;
  logic          bvalid_q, rvalid_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [DW-1:0] rdata_q;
  logic          wb_rst_q;

  // Byte-offset bits are meaningless on a word-addressed bus
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0]};

  logic wr_ok, rd_ok, pick_rd, launch_wr, launch_rd, in_wb, tmo_hit, term, ack_ok;

  assign wr_ok     = aw_full && w_full;
  assign rd_ok     = ar_full;
  // On a collision serve the opposite of whatever won the last collision
  assign pick_rd   = rd_ok && (!wr_ok || !lwr_q);
  assign launch_wr = (state_q == IDLE) && wr_ok && !pick_rd;
  assign launch_rd = (state_q == IDLE) && pick_rd;
  assign in_wb     = (state_q == WB_WR) || (state_q == WB_RD);
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
  assign term      = in_wb && (i_wb_ack || i_wb_err || tmo_hit);
  // err dominates ack; ack dominates a coincident timeout
  assign ack_ok    = i_wb_ack && !i_wb_err;

  axil2wb_skid #(.W(WA)) u_aw (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(i_axi_awvalid),
    .data_i(i_axi_awaddr[C_AXI_ADDR_WIDTH-1:2]), .ready_o(o_axi_awready),
    .pop_i(launch_wr), .full_o(aw_full), .data_o(aw_adr)
  );

  axil2wb_skid #(.W(SW+DW)) u_w (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(i_axi_wvalid),
    .data_i({i_axi_wstrb, i_axi_wdata}), .ready_o(o_axi_wready),
    .pop_i(launch_wr), .full_o(w_full), .data_o(w_data)
  );

  axil2wb_skid #(.W(WA)) u_ar (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(i_axi_arvalid),
    .data_i(i_axi_araddr[C_AXI_ADDR_WIDTH-1:2]), .ready_o(o_axi_arready),
    .pop_i(launch_rd), .full_o(ar_full), .data_o(ar_adr)
  );

  // Wishbone reset: asserts with rst_ni, releases on the next clock edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wb_rst_q <= 1'b1;
    else         wb_rst_q <= 1'b0;
  end

  // Bridge FSM: launch, hold bus until termination, hold AXI response until accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      lwr_q    <= 1'b1;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      tmo_q    <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch_wr) begin
            state_q <= WB_WR;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            adr_q   <= aw_adr;
            dat_q   <= w_data[DW-1:0];
            sel_q   <= w_data[SW+DW-1:DW];
            tmo_q   <= '0;
            if (rd_ok) lwr_q <= 1'b0;
          end else if (launch_rd) begin
            state_q <= WB_RD;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= ar_adr;
            sel_q   <= '1;
            tmo_q   <= '0;
            if (wr_ok) lwr_q <= 1'b1;
          end
        end
        WB_WR, WB_RD: begin
          if (term) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (state_q == WB_WR) begin
              state_q  <= B_RESP;
              bvalid_q <= 1'b1;
              bresp_q  <= ack_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
              state_q  <= R_RESP;
              rvalid_q <= 1'b1;
              rresp_q  <= ack_ok ? RESP_OKAY : RESP_SLVERR;
              rdata_q  <= ack_ok ? i_wb_dat : '0;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        B_RESP: begin
          if (i_axi_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        R_RESP: begin
          if (i_axi_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_wb_rst     = wb_rst_q;
  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = stb_q;
  assign o_wb_we      = we_q;
  assign o_wb_adr     = adr_q;
  assign o_wb_dat     = dat_q;
  assign o_wb_sel     = sel_q;
  assign o_axi_bvalid = bvalid_q;
  assign o_axi_bresp  = bresp_q;
  assign o_axi_rvalid = rvalid_q;
  assign o_axi_rresp  = rresp_q;
  assign o_axi_rdata  = rdata_q;

endmodule

// File: doc/axil2wb_bridge.md
Name: axil2wb_bridge

Overview:
- AXI4-lite slave to Wishbone classic master bridge. Sits directly upstream of the Wishbone-based crypto cores (AES first) inside their AXI4-lite top wrappers.
- Supports a single outstanding Wishbone transaction.
- Write and read requests are arbitrated fairly.
- A bus-hang timeout converts an unresponsive slave into SLVERR.

Parameters:
- C_AXI_DATA_WIDTH, 32, AXI/WB data width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 32, AXI byte-address width.
- TIMEOUT_CYCLES, 1024, cycles with cyc high and no ack/err before forced termination; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- i_axi_awvalid/o_axi_awready  in/out  1  write-address handshake
- i_axi_awaddr  in  C_AXI_ADDR_WIDTH  write byte address
- i_axi_wvalid/o_axi_wready  in/out  1  write-data handshake
- i_axi_wdata  in  32  write data
- i_axi_wstrb  in  4  byte strobes
- o_axi_bvalid/i_axi_bready  out/in  1  write-response handshake
- o_axi_bresp  out  2  00 OKAY, 10 SLVERR
- i_axi_arvalid/o_axi_arready  in/out  1  read-address handshake
- i_axi_araddr  in  C_AXI_ADDR_WIDTH  read byte address
- o_axi_rvalid/i_axi_rready  out/in  1  read-data handshake
- o_axi_rdata  out  32  read data
- o_axi_rresp  out  2  00 OKAY, 10 SLVERR
- o_wb_rst  out  1  Wishbone reset (registered ~rst_ni; asserts asynchronously, deasserts on the next clk_i edge)
- o_wb_cyc, o_wb_stb, o_wb_we  out  1  Wishbone cycle, strobe, write-enable
- o_wb_adr  out  C_AXI_ADDR_WIDTH-2  word address = axaddr[C_AXI_ADDR_WIDTH-1:2]
- o_wb_dat  out  32  write data
- o_wb_sel  out  4  byte selects
- i_wb_dat  in  32  read data
- i_wb_ack, i_wb_err  in  1  slave termination

Behaviour:
- Reset values:
  - All AXI valid outputs and o_wb_cyc/stb/we are 0; resp, rdata, adr, dat and sel are 0; o_wb_rst is 1.
  - AW, W and AR holding buffers are empty; FSM is in IDLE; last_was_read=1, so the first collision serves the write.
- Holding buffers: one entry each for AW, W and AR.
  - awready=!aw_full, wready=!w_full, arready=!ar_full.
  - AW and W may arrive in any order or in the same cycle.
  - A buffer empties in the cycle its transaction launches, so the next request can be accepted while the current one is in flight.
- FSM states: IDLE, WB_WR, WB_RD, B_RESP, R_RESP.
  - IDLE -> WB_WR when aw_full&&w_full. IDLE -> WB_RD when ar_full.
  - When both are eligible, serve the opposite of last_was_read, then update last_was_read.
  - Launch is registered: o_wb_cyc and o_wb_stb rise on the first edge after both buffers are full as seen in IDLE.
  - Write: we=1, sel=wstrb, dat=wdata. Read: we=0, sel=4'hF.
  - In WB_WR/WB_RD, cyc, stb, adr, dat, sel and we are held stable until termination.
  - Termination on i_wb_ack, i_wb_err, or timeout. On the next edge cyc=stb=we=0 and the FSM moves to B_RESP (bvalid=1) or R_RESP (rvalid=1).
- Response codes:
  - ack gives OKAY. err or timeout gives SLVERR.
  - ack and err in the same cycle gives SLVERR. ack and timeout in the same cycle gives OKAY.
  - Read data is captured from i_wb_dat on ack, and is 0 on err or timeout.
- Response hold: bvalid/rvalid are held with stable resp/data until bready/rready. The handshake cycle returns the FSM to IDLE, and a new launch may occur on the following edge.
  - Minimum write latency: AW/W handshake at edge N, cyc from N+1; a slave ack at N+1 gives bvalid from N+2.
- Timeout counter:
  - Clears at launch and increments each cycle cyc is high.
  - When it reaches TIMEOUT_CYCLES-1 with no ack/err, the transaction terminates. cyc is therefore high for exactly TIMEOUT_CYCLES cycles.
- i_wb_ack/i_wb_err outside WB_WR/WB_RD are ignored.
- Reset mid-operation: all outputs go to reset values immediately (async). The in-flight transaction is dropped with no AXI response.

Decomposition:
- Shared package axi_wb_pkg holds:
  - resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the state enum;
  - default widths.
- One natural sub-module, axil2wb_skid: a single-entry holding register with valid/ready. It is instantiated three times (AW, W, AR).

Test Plan:
1. Basic write: AW 0x10 and W 0xDEADBEEF/0xF in the same cycle; slave acks 3 cycles after cyc -> o_wb_adr=0x4, we=1, sel=0xF, dat=0xDEADBEEF; bvalid one cycle after ack, bresp=00.
2. Split write: W 0x0000A5A5 with strb 0x3, then AW 0x20 two cycles later -> no cyc until AW is accepted; then adr=0x8, sel=0x3; bresp=00.
3. Basic read: AR 0x8; slave acks with 0x12345678 -> rvalid, rdata=0x12345678, rresp=00. With rready held low 5 cycles, rvalid/rdata remain stable and arready stays 1.
4. Arbitration: simultaneous AR 0x0 and AW/W 0x4 after reset -> write is served first, then read. Repeated collision -> read is served first.
5. Errors: TIMEOUT_CYCLES=16 with a silent slave on a write -> cyc high exactly 16 cycles, bresp=10. Read with i_wb_err -> rresp=10, rdata=0.
6. Reset while cyc=1 in WB_RD -> cyc/stb/rvalid=0 immediately, o_wb_rst=1. After release, the first AR completes normally.
